seg_scan_driver: RTL

Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display with per-digit decimal point.
- Each digit shows a BCD value, a dash for invalid codes, or a rotating single-segment "spinner"; each digit can blink independently.
- New display contents are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new values.
- Sits between the application datapath and the board's segment/anode pins.

---
 rtl/seg7_pkg.sv | 31 +++
 rtl/seg_glyph.sv | 35 +++
 rtl/seg_scan_driver.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment scan driver.
// Segment order is {g,f,e,d,c,b,a}; all patterns are active-low.
package seg7_pkg;

  localparam int SPIN_STEPS = 6;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] DIGIT_GLYPH [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  typedef logic [2:0] spin_step_t;

  // Spinner lights one outer segment (a..f) per step; g is never used.
  function automatic logic [6:0] spin_pattern(input spin_step_t step);
    spin_pattern = SEG_BLANK;
    if (int'(step) < SPIN_STEPS) spin_pattern[step] = 1'b0;
  endfunction

endpackage

// File: rtl/seg_glyph.sv
// Combinational glyph decoder: one digit's code/flags to active-low segments.
module seg_glyph
  import seg7_pkg::*;
(
  input  logic       [3:0] code,
  input  logic             dp,
  input  logic             spin,
  input  spin_step_t       spin_step,
  input  logic             blank,
  output logic       [6:0] seg,
  output logic             seg_dpt
);

  // Priority: blank, then spinner, then BCD digit, then dash for invalid codes.
  always_comb begin
    // NOTE: both outputs get a default first so no path leaves them unassigned (no latch).
    seg     = SEG_BLANK;
    seg_dpt = 1'b1;
    if (blank) begin
      seg     = SEG_BLANK;
      seg_dpt = 1'b1;
    end else if (spin) begin
      seg     = spin_pattern(spin_step);
      seg_dpt = 1'b1;
    end else if (code <= 4'd9) begin
      seg     = DIGIT_GLYPH[code];
      seg_dpt = ~dp;
    end else begin
      // Invalid BCD: dash plus a lit decimal point as an error flag.
      seg     = SEG_DASH;
      seg_dpt = 1'b0;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with double-buffered
// contents committed at frame boundaries, per-digit blink and a shared spinner.
module seg_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter int SPIN_FRAMES  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blink_en,
  input  logic [N_DIGITS-1:0]   spin_en,
  output logic [6:0]            seg,
  output logic                  seg_dpt,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int SPC_W = (SPIN_FRAMES > 1) ? $clog2(SPIN_FRAMES) : 1;

  logic [CNT_W-1:0] scan_cnt;
  logic [IDX_W-1:0] idx;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_phase;
  logic [SPC_W-1:0] spin_cnt;
  spin_step_t       spin_step;
  logic             wrap_d;

  logic [4*N_DIGITS-1:0] pend_digits, shd_digits;
  logic [N_DIGITS-1:0]   pend_dp, shd_dp;
  logic [N_DIGITS-1:0]   pend_blink, shd_blink;
  logic [N_DIGITS-1:0]   pend_spin, shd_spin;
  logic                  pend_flag;
  logic                  shd_valid;

  logic       scan_wrap, frame_wrap;
  logic [3:0] cur_code;
  logic       cur_blank;
  logic [6:0] g_seg;
  logic       g_dpt;

  assign scan_wrap  = (scan_cnt == CNT_W'(SCAN_DIV - 1));
  assign frame_wrap = scan_wrap && (idx == IDX_W'(N_DIGITS - 1));

  // Scan position, frame-rate blink/spin counters and the frame-wrap delay for frame_tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt    <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      spin_cnt    <= '0;
      spin_step   <= '0;
      wrap_d      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      wrap_d   <= frame_wrap;
      if (scan_wrap) idx <= frame_wrap ? '0 : idx + 1'b1;
      if (frame_wrap) begin
        if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
        if (spin_cnt == SPC_W'(SPIN_FRAMES - 1)) begin
          spin_cnt  <= '0;
          spin_step <= (spin_step == spin_step_t'(SPIN_STEPS - 1)) ? '0 : spin_step + 1'b1;
        end else begin
          spin_cnt <= spin_cnt + 1'b1;
        end
      end
    end
  end

  // Pending/shadow double buffer: shadow only changes on a frame wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the buffers are small register banks, so resetting them is cheap and keeps the display deterministic.
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_blink  <= '0;
      pend_spin   <= '0;
      pend_flag   <= 1'b0;
      shd_digits  <= '0;
      shd_dp      <= '0;
      shd_blink   <= '0;
      shd_spin    <= '0;
      shd_valid   <= 1'b0;
    end else if (load && frame_wrap) begin
      // Load coinciding with the wrap goes straight into the frame starting now.
      shd_digits <= digits_in;
      shd_dp     <= dp_in;
      shd_blink  <= blink_en;
      shd_spin   <= spin_en;
      shd_valid  <= 1'b1;
      pend_flag  <= 1'b0;
    end else begin
      if (load) begin
        pend_digits <= digits_in;
        pend_dp     <= dp_in;
        pend_blink  <= blink_en;
        pend_spin   <= spin_en;
        pend_flag   <= 1'b1;
      end
      if (frame_wrap && pend_flag) begin
        shd_digits <= pend_digits;
        shd_dp     <= pend_dp;
        shd_blink  <= pend_blink;
        shd_spin   <= pend_spin;
        shd_valid  <= 1'b1;
        pend_flag  <= 1'b0;
      end
    end
  end

  assign cur_code  = shd_digits[{idx, 2'b00} +: 4];
  assign cur_blank = ~shd_valid | (blink_phase & shd_blink[idx]);

  seg_glyph u_glyph (
    .code      (cur_code),
    .dp        (shd_dp[idx]),
    .spin      (shd_spin[idx]),
    .spin_step (spin_step),
    .blank     (cur_blank),
    .seg       (g_seg),
    .seg_dpt   (g_dpt)
  );

  // Registered pin drivers: one cycle behind the scan index; dark until contents are first committed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= SEG_BLANK;
      seg_dpt    <= 1'b1;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      seg        <= g_seg;
      seg_dpt    <= g_dpt;
      an         <= shd_valid ? ~(N_DIGITS'(1) << idx) : '1;
      frame_tick <= wrap_d;
    end
  end

endmodule
